// File: rtl/sys_defs.sv
// Shared definitions for the load path.
// XLEN / ROB_TAG_W      : datapath and reorder-buffer tag widths
// LB_DEPTH_DEFAULT      : default number of queued loads in load_buffer
// LB_STATE              : load_buffer FSM encoding
// MEM_SIZE              : mem_size[1:0] access width encoding
// LB_ENTRY              : one queued load
// LB_PACKET / CDB_DATA  : interface structs shared with the address unit and CDB
package sys_defs;

  localparam int XLEN             = 32;
  localparam int ROB_TAG_W        = 5;
  localparam int LB_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    LB_IDLE = 2'd0,
    LB_REQ  = 2'd1,
    LB_RESP = 2'd2
  } LB_STATE;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  // mem_size[2] = 1 selects zero extension, 0 selects sign extension.
  typedef struct packed {
    logic [XLEN-1:0]      address;
    logic [ROB_TAG_W-1:0] rd_tag;
    logic [2:0]           mem_size;
  } LB_ENTRY;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      address;
    logic [ROB_TAG_W-1:0] rd_tag;
    logic [2:0]           mem_size;
  } LB_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } CDB_DATA;

endpackage

// File: rtl/load_data_align.sv
// Combinational lane select and extension of a returned memory word.
// rdata    : aligned 32-bit word from memory
// addr     : low two bits of the load byte address
// mem_size : [1:0] access width (MEM_SIZE), [2] zero-extend when set
// value    : extended result
// Also intended for reuse by store-to-load forwarding.
module load_data_align
  import sys_defs::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      mem_size,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sign_fill;

  always_comb begin
    byte_lane = rdata[{addr, 3'b000} +: 8];
    // Halfword lane comes from addr[1] alone; addr[0] is ignored.
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    sign_fill = 1'b0;
    value     = rdata;
    case (MEM_SIZE'(mem_size[1:0]))
      BYTE: begin
        sign_fill = ~mem_size[2] & byte_lane[7];
        value     = {{(XLEN-8){sign_fill}}, byte_lane};
      end
      HALF: begin
        sign_fill = ~mem_size[2] & half_lane[15];
        value     = {{(XLEN-16){sign_fill}}, half_lane};
      end
      default: value = rdata;  // WORD and DOUBLE pass the word through
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// In-order load buffer between the address calculation unit and the data
// memory read port. Loads are queued, issued one at a time, the returned
// word is aligned/extended, and the result is held on the CDB until granted.
// clock, reset_n   : clock, asynchronous active-low reset
// lb_packet_in     : load from the address unit; ignored while lb_full
// lb_full          : buffer holds LB_DEPTH loads
// squash           : flush every queued and in-flight load
// mem_req/mem_addr : read request and word-aligned address
// mem_ack/mem_rdata: read completion and data (ack only used while mem_req)
// cdb_out          : result broadcast, held until cdb_grant
// dbg_state        : FSM state
// dbg_count        : number of occupied entries
//
// Handshakes: the memory read completes on the cycle mem_req && mem_ack;
// the broadcast completes on the cycle cdb_out.valid && cdb_grant. A
// request may be withdrawn (squash/reset) before it is acknowledged.
// All outputs decode from registered state, so no combinational path
// runs from mem_ack or cdb_grant to any output.
module load_buffer
  import sys_defs::*;
#(
  parameter int LB_DEPTH = LB_DEPTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  LB_PACKET                   lb_packet_in,
  output logic                       lb_full,
  input  logic                       squash,
  output logic                       mem_req,
  output logic [XLEN-1:0]            mem_addr,
  input  logic                       mem_ack,
  input  logic [XLEN-1:0]            mem_rdata,
  output CDB_DATA                    cdb_out,
  input  logic                       cdb_grant,
  output LB_STATE                    dbg_state,
  output logic [$clog2(LB_DEPTH):0]  dbg_count
);

  localparam int             PTR_W    = $clog2(LB_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(LB_DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  LB_ENTRY          fifo [LB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  LB_STATE          state;
  logic [XLEN-1:0]  result;
  LB_ENTRY          head_entry;
  logic [XLEN-1:0]  aligned;
  logic             enq;
  logic             pop;

  assign head_entry = fifo[head];
  assign lb_full    = (count == FULL_CNT);
  assign enq        = lb_packet_in.valid & ~lb_full & ~squash;
  assign pop        = (state == LB_RESP) & cdb_grant & ~squash;

  load_data_align u_align (
    .rdata    (mem_rdata),
    .addr     (head_entry.address[1:0]),
    .mem_size (head_entry.mem_size),
    .value    (aligned)
  );

  // Entry storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clock) begin
    if (enq) begin
      fifo[tail] <= '{address:  lb_packet_in.address,
                      rd_tag:   lb_packet_in.rd_tag,
                      mem_size: lb_packet_in.mem_size};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      state  <= LB_IDLE;
      result <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= LB_IDLE;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case (state)
        LB_IDLE: if (count != '0) state <= LB_REQ;
        LB_REQ: begin
          if (mem_ack) begin
            result <= aligned;
            state  <= LB_RESP;
          end
        end
        LB_RESP: begin
          // A load enqueued on the pop cycle keeps the request path busy.
          if (cdb_grant) state <= ((count > ONE_CNT) || enq) ? LB_REQ : LB_IDLE;
        end
        default: state <= LB_IDLE;
      endcase
    end
  end

  assign mem_req  = (state == LB_REQ);
  assign mem_addr = mem_req ? {head_entry.address[XLEN-1:2], 2'b00} : '0;

  always_comb begin
    cdb_out = '0;
    if (state == LB_RESP) begin
      cdb_out.valid   = 1'b1;
      cdb_out.value   = result;
      cdb_out.rob_tag = head_entry.rd_tag;
    end
  end

  assign dbg_state = state;
  assign dbg_count = count;

endmodule

// File: tb/tb_load_buffer.sv
module tb_load_buffer;
  import sys_defs::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset_n;
  LB_PACKET    lb_packet_in;
  logic        lb_full;
  logic        squash;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  CDB_DATA     cdb_out;
  logic        cdb_grant;
  LB_STATE     dbg_state;
  logic [2:0]  dbg_count;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];  // {rob_tag, value} in expected broadcast order

  always #5 clock = ~clock;

  load_buffer #(.LB_DEPTH(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .lb_packet_in (lb_packet_in),
    .lb_full      (lb_full),
    .squash       (squash),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .cdb_out      (cdb_out),
    .cdb_grant    (cdb_grant),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_load(input logic [31:0] addr, input logic [4:0] tag, input logic [2:0] size);
    lb_packet_in = '{valid: 1'b1, address: addr, rd_tag: tag, mem_size: size};
    tick();
    lb_packet_in.valid = 1'b0;
  endtask

  task automatic check_cdb(input string name);
    logic [36:0] e;
    chk({name, "_sb_avail"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, "_cdb_valid"}, cdb_out.valid, 1);
      chk({name, "_cdb_value"}, cdb_out.value, e[31:0]);
      chk({name, "_cdb_tag"}, cdb_out.rob_tag, e[36:32]);
    end
  endtask

  // One load served with ack on its first request cycle.
  task automatic run_one(input string name, input logic [31:0] addr, input logic [4:0] tag,
                         input logic [2:0] size, input logic [31:0] rdata,
                         input logic [31:0] exp_val, input int hold);
    exp_q.push_back({tag, exp_val});
    push_load(addr, tag, size);
    chk({name, "_idle_no_req"}, mem_req, 0);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    chk({name, "_req"}, mem_req, 1);
    chk({name, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    tick();
    mem_ack = 1'b0;
    chk({name, "_req_dropped"}, mem_req, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({name, "_hold_valid"}, cdb_out.valid, 1);
    end
    check_cdb(name);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    chk({name, "_after_grant_valid"}, cdb_out.valid, 0);
    chk({name, "_after_grant_count"}, dbg_count, 0);
  endtask

  // A producer must never present a load while the buffer is full.
  always @(negedge clock) begin
    if (reset_n && lb_packet_in.valid) chk("enq_while_full", lb_full, 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [4:0]  t;
    logic [31:0] a;
    reset_n      = 1'b0;
    lb_packet_in = '0;
    squash       = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    cdb_grant    = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_full", lb_full, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_cdb", {cdb_out.valid, cdb_out.value[30:0]}, 0);
    chk("rst_state", dbg_state, LB_IDLE);
    chk("rst_count", dbg_count, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_req", mem_req, 0);
    chk("post_rst_cdb_valid", cdb_out.valid, 0);

    // Signed byte, lane 3, held two cycles before grant.
    run_one("lb", 32'h0000_1003, 5'd5, 3'b000, 32'h80FF_7F01, 32'hFFFF_FF80, 2);
    // Unsigned/signed half, word, unsigned byte, size 3 passthrough.
    run_one("lhu", 32'h0000_2002, 5'd6, 3'b101, 32'hBEEF_1234, 32'h0000_BEEF, 0);
    run_one("lh", 32'h0000_2000, 5'd7, 3'b001, 32'h0000_8001, 32'hFFFF_8001, 0);
    run_one("lw", 32'h0000_2004, 5'd8, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    run_one("lbu", 32'h0000_3001, 5'd9, 3'b100, 32'h0000_A500, 32'h0000_00A5, 0);
    run_one("ld", 32'h0000_3003, 5'd10, 3'b011, 32'h8765_4321, 32'h8765_4321, 0);

    // Fill with four word loads, no ack.
    for (int i = 1; i <= 4; i++) begin
      t = 5'(i);
      exp_q.push_back({t, 32'hA000_0000 | {27'd0, t}});
      push_load(32'h0000_4000 + {25'd0, t - 5'd1, 2'b00}, t, 3'b010);
    end
    chk("fill_full", lb_full, 1);
    chk("fill_count", dbg_count, 4);
    chk("fill_req", mem_req, 1);
    chk("fill_addr0", mem_addr, 32'h0000_4000);
    for (int k = 0; k < 5; k++) begin
      t = 5'(k + 1);
      a = 32'h0000_4000 + {25'd0, t - 5'd1, 2'b00};
      repeat (3) tick();
      chk("fill_req_hold", mem_req, 1);
      chk("fill_addr", mem_addr, a);
      mem_rdata = 32'hA000_0000 | {27'd0, t};
      mem_ack   = 1'b1;
      tick();
      mem_ack = 1'b0;
      repeat (2) tick();
      if (k == 0) chk("full_before_pop", lb_full, 1);
      check_cdb("fill");
      cdb_grant = 1'b1;
      if (k == 1) begin
        // Enqueue on a pop cycle: occupancy stays put.
        exp_q.push_back({5'd5, 32'hA000_0005});
        lb_packet_in = '{valid: 1'b1, address: 32'h0000_4010, rd_tag: 5'd5, mem_size: 3'b010};
      end
      tick();
      cdb_grant          = 1'b0;
      lb_packet_in.valid = 1'b0;
      if (k == 0) begin
        chk("full_drop_after_pop", lb_full, 0);
        chk("count_after_pop", dbg_count, 3);
      end
      if (k == 1) chk("count_enq_and_pop", dbg_count, 3);
    end
    chk("fill_end_state", dbg_state, LB_IDLE);
    chk("fill_end_count", dbg_count, 0);
    chk("fill_sb_drained", exp_q.size(), 0);

    // Squash in LB_REQ with three queued and ack in the same cycle.
    push_load(32'h0000_5000, 5'd11, 3'b010);
    push_load(32'h0000_5004, 5'd12, 3'b010);
    push_load(32'h0000_5008, 5'd13, 3'b010);
    chk("sq_req_pre", mem_req, 1);
    chk("sq_count_pre", dbg_count, 3);
    squash    = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    squash  = 1'b0;
    mem_ack = 1'b0;
    chk("sq_req", mem_req, 0);
    chk("sq_full", lb_full, 0);
    chk("sq_count", dbg_count, 0);
    chk("sq_cdb", cdb_out.valid, 0);
    chk("sq_state", dbg_state, LB_IDLE);
    repeat (3) begin
      tick();
      chk("sq_no_cdb", cdb_out.valid, 0);
      chk("sq_no_req", mem_req, 0);
    end
    run_one("sq_fresh", 32'h0000_6002, 5'd14, 3'b001, 32'h7FFF_1234, 32'h0000_7FFF, 0);

    // Squash in LB_RESP together with cdb_grant.
    push_load(32'h0000_7000, 5'd15, 3'b010);
    push_load(32'h0000_7004, 5'd16, 3'b010);
    mem_rdata = 32'h0000_0777;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sqr_cdb_valid", cdb_out.valid, 1);
    chk("sqr_cdb_tag", cdb_out.rob_tag, 15);
    squash    = 1'b1;
    cdb_grant = 1'b1;
    tick();
    squash    = 1'b0;
    cdb_grant = 1'b0;
    chk("sqr_cdb_gone", cdb_out.valid, 0);
    chk("sqr_count", dbg_count, 0);
    chk("sqr_state", dbg_state, LB_IDLE);
    repeat (2) tick();
    chk("sqr_no_cdb", cdb_out.valid, 0);
    chk("sqr_no_req", mem_req, 0);

    // Asynchronous reset in the middle of LB_RESP.
    push_load(32'h0000_8000, 5'd17, 3'b010);
    mem_rdata = 32'h0000_0888;
    mem_ack   = 1'b1;
    tick();
    tick();
    chk("ar_cdb_before", cdb_out.valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_cdb_async", cdb_out.valid, 0);
    chk("ar_req_async", mem_req, 0);
    chk("ar_state_async", dbg_state, LB_IDLE);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    mem_ack = 1'b0;
    repeat (3) tick();
    chk("ar_idle_state", dbg_state, LB_IDLE);
    chk("ar_idle_req", mem_req, 0);
    chk("ar_idle_count", dbg_count, 0);
    chk("ar_idle_cdb", cdb_out.valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
